// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan engine: runs IR/DR scans of up to DATA_W bits on a TAP from the system clock
// and returns the captured TDO bits through a valid/ready response channel.
module jtag_scan_master #(
    parameter int DATA_W  = 38,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ir,
    input  logic [5:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              tap_reset_req,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       LEN_MAX  = 6'(DATA_W);

    // TMS sequences are stored LSB-first; tms always shows bit 0 of the remaining sequence
    localparam logic [5:0] SEQ_TAPRST = 6'b011111;
    localparam logic [5:0] SEQ_HDR_DR = 6'b000001;
    localparam logic [5:0] SEQ_HDR_IR = 6'b000011;
    localparam logic [5:0] SEQ_TRL    = 6'b000001;

    typedef enum logic [2:0] {
        TAPRST,
        IDLE,
        HDR,
        SHIFT,
        TRL,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0]  div_cnt;
    logic              tck_run;
    logic              tck_rise;
    logic              tck_fall;
    logic [5:0]        seq_bits;
    logic [2:0]        seq_cnt;
    logic              seq_done;
    logic [5:0]        bit_cnt;
    logic [5:0]        len_q;
    logic [5:0]        len_clamped;
    logic [5:0]        shift_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] cap;
    logic              rst_pend;
    logic              accept;
    logic              reset_go;

    assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign tck_run     = (state == TAPRST) || (state == HDR) || (state == SHIFT) || (state == TRL);
    assign tck_rise    = tck_run && !tck && (div_cnt == DIV_LAST);
    assign tck_fall    = tck_run && tck && (div_cnt == DIV_LAST);
    assign seq_done    = (seq_cnt == 3'd0);
    assign shift_idx   = len_q - 6'd1 - bit_cnt;
    assign rsp_data    = cap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= TAPRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TAPRST: if (tck_fall && seq_done) state_nxt = IDLE;
            IDLE: begin
                if (reset_go) begin
                    state_nxt = TAPRST;
                end else if (accept) begin
                    state_nxt = (len_clamped == 6'd0) ? RESP : HDR;
                end
            end
            HDR:    if (tck_fall && seq_done) state_nxt = SHIFT;
            SHIFT:  if (tck_fall && (bit_cnt == 6'd0)) state_nxt = TRL;
            TRL:    if (tck_fall && seq_done) state_nxt = RESP;
            RESP:   if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = TAPRST;
        endcase
    end

    // A pending or same-cycle TAP reset request masks cmd_ready so a handshake is never dropped
    always_comb begin
        cmd_ready = (state == IDLE) && !rst_pend && !tap_reset_req;
        rsp_valid = (state == RESP);
        reset_go  = (state == IDLE) && (rst_pend || tap_reset_req);
        accept    = cmd_valid && cmd_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            tck      <= 1'b0;
            tms      <= 1'b1;
            tdi      <= 1'b0;
            seq_bits <= SEQ_TAPRST;
            seq_cnt  <= 3'd5;
            bit_cnt  <= '0;
            len_q    <= '0;
            shreg    <= '0;
            cap      <= '0;
            rst_pend <= 1'b0;
        end else begin
            if (reset_go) begin
                rst_pend <= 1'b0;
            end else if (tap_reset_req) begin
                rst_pend <= 1'b1;
            end

            if (tck_run) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    tck     <= ~tck;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
                tck     <= 1'b0;
            end

            if (tck_rise && (state == SHIFT)) begin
                cap[shift_idx] <= tdo;
            end

            // TMS/TDI only move on the TCK falling edge, or when a sequence starts with TCK low
            case (state)
                IDLE: begin
                    if (reset_go) begin
                        seq_bits <= SEQ_TAPRST;
                        seq_cnt  <= 3'd5;
                        tms      <= 1'b1;
                    end else if (accept) begin
                        len_q <= len_clamped;
                        shreg <= cmd_data;
                        cap   <= '0;
                        if (len_clamped != 6'd0) begin
                            seq_bits <= cmd_ir ? SEQ_HDR_IR : SEQ_HDR_DR;
                            seq_cnt  <= cmd_ir ? 3'd3 : 3'd2;
                            tms      <= 1'b1;
                        end
                    end
                end
                TAPRST, HDR, TRL: begin
                    if (tck_fall) begin
                        if (!seq_done) begin
                            seq_bits <= seq_bits >> 1;
                            seq_cnt  <= seq_cnt - 3'd1;
                            tms      <= seq_bits[1];
                        end else if (state == HDR) begin
                            bit_cnt <= len_q - 6'd1;
                            tms     <= (len_q == 6'd1);
                            tdi     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                SHIFT: begin
                    if (tck_fall) begin
                        if (bit_cnt != 6'd0) begin
                            bit_cnt <= bit_cnt - 6'd1;
                            tms     <= (bit_cnt == 6'd1);
                            tdi     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end else begin
                            seq_bits <= SEQ_TRL;
                            seq_cnt  <= 3'd1;
                            tms      <= 1'b1;
                            tdi      <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP (2-bit IR capturing 2'b01, 38-bit DR) plus a scoreboard
// of expected responses, latencies and TMS sequences pushed when each command is issued.
module tb_jtag_scan_master;

    localparam int DATA_W  = 38;
    localparam int CLK_DIV = 2;

    logic              clk           = 1'b0;
    logic              reset_n       = 1'b0;
    logic              cmd_valid     = 1'b0;
    logic              cmd_ir        = 1'b0;
    logic [5:0]        cmd_len       = '0;
    logic [DATA_W-1:0] cmd_data      = '0;
    logic              rsp_ready     = 1'b1;
    logic              tap_reset_req = 1'b0;
    logic              tdo           = 1'b0;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              tck;
    logic              tms;
    logic              tdi;

    jtag_scan_master #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_ir        (cmd_ir),
        .cmd_len       (cmd_len),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .tap_reset_req (tap_reset_req),
        .tck           (tck),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo)
    );

    always #5 clk = ~clk;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SHF_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHF_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    tap_t              tap_state     = TLR;
    logic [1:0]        ir_reg        = 2'b00;
    logic [1:0]        ir_sh         = 2'b00;
    logic [DATA_W-1:0] dr_reg        = '0;
    logic [DATA_W-1:0] dr_sh         = '0;
    logic              dr_preload_en = 1'b0;
    logic [DATA_W-1:0] dr_preload    = '0;

    // Behavioural TAP: register actions happen on the rising edge that leaves the state
    always @(posedge tck) begin
        case (tap_state)
            CAP_IR:  ir_sh  <= 2'b01;
            SHF_IR:  ir_sh  <= {tdi, ir_sh[1]};
            UPD_IR:  ir_reg <= ir_sh;
            CAP_DR:  dr_sh  <= dr_preload_en ? dr_preload : dr_reg;
            SHF_DR:  dr_sh  <= {tdi, dr_sh[DATA_W-1:1]};
            UPD_DR:  dr_reg <= dr_sh;
            default: ;
        endcase
        case (tap_state)
            TLR:    tap_state <= tms ? TLR    : RTI;
            RTI:    tap_state <= tms ? SEL_DR : RTI;
            SEL_DR: tap_state <= tms ? SEL_IR : CAP_DR;
            CAP_DR: tap_state <= tms ? EX1_DR : SHF_DR;
            SHF_DR: tap_state <= tms ? EX1_DR : SHF_DR;
            EX1_DR: tap_state <= tms ? UPD_DR : PAU_DR;
            PAU_DR: tap_state <= tms ? EX2_DR : PAU_DR;
            EX2_DR: tap_state <= tms ? UPD_DR : SHF_DR;
            UPD_DR: tap_state <= tms ? SEL_DR : RTI;
            SEL_IR: tap_state <= tms ? TLR    : CAP_IR;
            CAP_IR: tap_state <= tms ? EX1_IR : SHF_IR;
            SHF_IR: tap_state <= tms ? EX1_IR : SHF_IR;
            EX1_IR: tap_state <= tms ? UPD_IR : PAU_IR;
            PAU_IR: tap_state <= tms ? EX2_IR : PAU_IR;
            EX2_IR: tap_state <= tms ? UPD_IR : SHF_IR;
            default: tap_state <= tms ? SEL_DR : RTI;
        endcase
    end

    always @(negedge tck) begin
        tdo <= (tap_state == SHF_IR) ? ir_sh[0] : (tap_state == SHF_DR) ? dr_sh[0] : 1'b0;
    end

    int          tck_edges = 0;
    logic [63:0] tms_hist  = '0;

    always @(posedge tck) begin
        tck_edges <= tck_edges + 1;
        tms_hist  <= {tms_hist[62:0], tms};
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        int                lat;
        int                tcks;
        logic [63:0]       tms_seq;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   tck_base    = 0;
    int   lat_count   = 0;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no end of sequence, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input logic [5:0] len);
        return (int'(len) > DATA_W) ? DATA_W : int'(len);
    endfunction

    function automatic logic [63:0] exp_tms(input logic ir, input int len);
        logic [63:0] s;
        if (len == 0) return 64'd0;
        s = ir ? 64'b1100 : 64'b100;
        for (int k = 0; k < len; k++) s = {s[62:0], (k == len - 1)};
        s = {s[61:0], 2'b10};
        return s;
    endfunction

    function automatic logic [63:0] last_tms(input int n);
        if (n <= 0) return 64'd0;
        return tms_hist & ((64'd1 << n) - 64'd1);
    endfunction

    task automatic apply_stimulus(input logic ir, input logic [5:0] len, input logic [DATA_W-1:0] data,
                                  input bit expect_rsp, input logic [DATA_W-1:0] exp_data);
        exp_t e;
        int   guard;
        int   l;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        l = eff_len(len);
        if (expect_rsp) begin
            e.data    = exp_data;
            e.lat     = (l == 0) ? 1 : (l + (ir ? 6 : 5)) * 2 * CLK_DIV + 1;
            e.tcks    = (l == 0) ? 0 : l + (ir ? 4 : 3) + 2;
            e.tms_seq = exp_tms(ir, l);
            exp_q.push_back(e);
        end
        tck_base  = tck_edges;
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat_count = 1;
    endtask

    task automatic await_response(input string tag);
        exp_t e;
        int   n;
        while (rsp_valid !== 1'b1 && lat_count < 4000) begin
            @(posedge clk); #1;
            lat_count++;
        end
        e = exp_q.pop_front();
        n = tck_edges - tck_base;
        check_output({tag, "_latency"}, 64'(lat_count), 64'(e.lat));
        check_output({tag, "_rsp_data"}, 64'(rsp_data), 64'(e.data));
        check_output({tag, "_tck_count"}, 64'(n), 64'(e.tcks));
        check_output({tag, "_tms_seq"}, last_tms(n), e.tms_seq);
        if (rsp_ready) begin
            @(posedge clk); #1;
            check_output({tag, "_rsp_release"}, 64'(rsp_valid), 64'd0);
        end
    endtask

    task automatic wait_ready(input string tag, input int start, input int exp_cycles);
        int cnt;
        int n;
        cnt      = start;
        tck_base = tck_edges;
        while (cmd_ready !== 1'b1 && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        n = tck_edges - tck_base;
        check_output({tag, "_ready_cycle"}, 64'(cnt), 64'(exp_cycles));
        check_output({tag, "_tck_count"}, 64'(n), 64'd6);
        check_output({tag, "_tms_seq"}, last_tms(n), 64'b111110);
        check_output({tag, "_tap_state"}, 64'(tap_state), 64'(RTI));
    endtask

    initial begin
        logic [DATA_W-1:0] held;
        bit                stable_ok;
        int                guard;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_lines", 64'({tck, tms, tdi, cmd_ready, rsp_valid}), 64'(5'b01000));
        check_output("reset_rsp_data", 64'(rsp_data), 64'd0);

        reset_n = 1'b1;
        wait_ready("powerup", 0, 12 * CLK_DIV);

        apply_stimulus(1'b1, 6'd2, 38'h3, 1'b1, 38'h1);
        await_response("ir_scan");
        check_output("ir_model_reg", 64'(ir_reg), 64'(2'b11));

        dr_preload_en = 1'b1;
        dr_preload    = 38'h15_1234_5678;
        apply_stimulus(1'b0, 6'd38, 38'h2A_5A5A_5A5A, 1'b1, 38'h15_1234_5678);
        await_response("dr_scan");
        check_output("dr_model_reg", 64'(dr_reg), 64'(38'h2A_5A5A_5A5A));

        apply_stimulus(1'b0, 6'd0, 38'h3F_FFFF_FFFF, 1'b1, 38'h0);
        await_response("len0");

        dr_preload = 38'h3F_FFFF_FFFF;
        apply_stimulus(1'b0, 6'd1, 38'h1, 1'b1, 38'h1);
        await_response("len1");

        dr_preload = 38'h01_0203_0405;
        apply_stimulus(1'b0, 6'd50, 38'h12_3456_789A, 1'b1, 38'h01_0203_0405);
        await_response("len_clamp");
        check_output("clamp_model_reg", 64'(dr_reg), 64'(38'h12_3456_789A));

        // Backpressure with a reset request raised mid-scan
        dr_preload = 38'h00_0000_00A5;
        rsp_ready  = 1'b0;
        apply_stimulus(1'b0, 6'd8, 38'hC3, 1'b1, 38'hA5);
        repeat (20) begin
            @(posedge clk); #1;
            lat_count++;
        end
        tap_reset_req = 1'b1;
        @(posedge clk); #1;
        lat_count++;
        tap_reset_req = 1'b0;
        await_response("bp_scan");
        held      = rsp_data;
        stable_ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_data !== held || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) stable_ok = 1'b0;
        end
        check_output("bp_hold_stable", 64'(stable_ok), 64'd1);
        check_output("bp_held_data", 64'(rsp_data), 64'(38'hA5));
        check_output("bp_model_reg", 64'(dr_reg), 64'({8'hC3, 30'h0}));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_output("bp_rsp_release", 64'(rsp_valid), 64'd0);
        wait_ready("bp_taprst", 1, 2 + 12 * CLK_DIV);

        // Asynchronous reset while shifting
        dr_preload_en = 1'b0;
        apply_stimulus(1'b0, 6'd20, 38'h0F_0F0F, 1'b0, 38'h0);
        repeat (30) @(posedge clk);
        #1;
        guard = 0;
        while (tck !== 1'b1 && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output("midreset_tck_high", 64'(tck), 64'd1);
        reset_n = 1'b0;
        #1;
        check_output("midreset_lines", 64'({tck, tms, tdi, cmd_ready, rsp_valid}), 64'(5'b01000));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ready("midreset_taprst", 0, 12 * CLK_DIV);

        apply_stimulus(1'b1, 6'd2, 38'h2, 1'b1, 38'h1);
        await_response("ir_after_reset");
        check_output("ir_after_reset_model", 64'(ir_reg), 64'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
